// File: rtl/sign_extend_jump_pkg.sv
// Shared CPU constants and a generic sign-extension helper used by the
// jump, branch and I-type immediate extenders.
package sign_extend_jump_pkg;

  localparam int DATA_W     = 16;
  localparam int IMM_W_JUMP = 12;

  // Extends the low from_width bits of value to DATA_W bits; upper input bits are ignored.
  function automatic logic [DATA_W-1:0] sext(input logic [DATA_W-1:0] value,
                                              input int               from_width);
    logic [DATA_W-1:0] upper_mask;
    logic              sign_bit;
    upper_mask = {DATA_W{1'b1}} << from_width;
    sign_bit   = |(value & (DATA_W'(1) << (from_width - 1)));
    return sign_bit ? (value | upper_mask) : (value & ~upper_mask);
  endfunction

endpackage

// File: rtl/sign_extend_jump_sext_unit.sv
// Parameterised purely combinational sign extender (IN_W -> OUT_W).
module sext_unit
  import sign_extend_jump_pkg::*;
#(
  parameter int IN_W  = IMM_W_JUMP,
  parameter int OUT_W = DATA_W
) (
  input  logic [IN_W-1:0]  in_val,
  output logic [OUT_W-1:0] out_val
);

  assign out_val = {{(OUT_W - IN_W){in_val[IN_W-1]}}, in_val};

endmodule

// File: rtl/sign_extend_jump.sv
// Jump immediate sign-extension and PC-relative target, combinational for the
// single-cycle datapath plus a one-cycle registered copy with a valid flag.
module sign_extend_jump #(
  parameter int IMM_W     = sign_extend_jump_pkg::IMM_W_JUMP,
  parameter int DATA_W    = sign_extend_jump_pkg::DATA_W,
  parameter int TGT_SHIFT = 0
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [IMM_W-1:0]  J_imm,
  input  logic [DATA_W-1:0] pc,
  input  logic              en,
  output logic [DATA_W-1:0] J_extend,
  output logic [DATA_W-1:0] J_target,
  output logic [DATA_W-1:0] J_extend_q,
  output logic [DATA_W-1:0] J_target_q,
  output logic              valid_q
);

  logic signed [DATA_W-1:0] j_ext_s;
  logic signed [DATA_W-1:0] offset_s;

  logic [DATA_W-1:0] j_extend_d;
  logic [DATA_W-1:0] j_target_d;
  logic              valid_d;
  logic [DATA_W-1:0] j_extend_q;
  logic [DATA_W-1:0] j_target_q;
  logic              valid_q_r;

  sext_unit #(
    .IN_W  (IMM_W),
    .OUT_W (DATA_W)
  ) u_sext (
    .in_val  (J_imm),
    .out_val (j_ext_s)
  );

  // Bits shifted past the MSB are dropped; the add wraps modulo 2^DATA_W.
  assign offset_s = j_ext_s <<< TGT_SHIFT;
  assign J_extend = j_ext_s;
  assign J_target = pc + offset_s;

  always_comb begin
    j_extend_d = j_extend_q;
    j_target_d = j_target_q;
    valid_d    = en;
    if (en) begin
      j_extend_d = J_extend;
      j_target_d = J_target;
    end
  end

  // Capture stage: results are visible one cycle after en.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      j_extend_q <= '0;
      j_target_q <= '0;
      valid_q_r  <= 1'b0;
    end else begin
      j_extend_q <= j_extend_d;
      j_target_q <= j_target_d;
      valid_q_r  <= valid_d;
    end
  end

  assign J_extend_q = j_extend_q;
  assign J_target_q = j_target_q;
  assign valid_q    = valid_q_r;

endmodule

// File: tb/tb_sign_extend_jump.sv
// Self-checking bench for sign_extend_jump: combinational checks plus a
// scoreboard for the registered path; a second instance covers TGT_SHIFT=1.
module tb_sign_extend_jump;

  logic        clk = 1'b0;
  logic        rst_n;
  logic [11:0] j_imm;
  logic [15:0] pc;
  logic        en;

  logic [15:0] ext0, tgt0, ext_q0, tgt_q0;
  logic        vld0;
  logic [15:0] ext1, tgt1, ext_q1, tgt_q1;
  logic        vld1;

  int total = 0;
  int bad   = 0;

  typedef struct {
    logic [15:0] e;
    logic [15:0] t;
    logic        v;
  } exp_t;

  exp_t        sb[$];
  logic [15:0] m_e, m_t;
  logic        m_v;

  always #5 clk = ~clk;

  sign_extend_jump #(.IMM_W(12), .DATA_W(16), .TGT_SHIFT(0)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .J_imm      (j_imm),
    .pc         (pc),
    .en         (en),
    .J_extend   (ext0),
    .J_target   (tgt0),
    .J_extend_q (ext_q0),
    .J_target_q (tgt_q0),
    .valid_q    (vld0)
  );

  sign_extend_jump #(.IMM_W(12), .DATA_W(16), .TGT_SHIFT(1)) dut_sh1 (
    .clk        (clk),
    .rst_n      (rst_n),
    .J_imm      (j_imm),
    .pc         (pc),
    .en         (en),
    .J_extend   (ext1),
    .J_target   (tgt1),
    .J_extend_q (ext_q1),
    .J_target_q (tgt_q1),
    .valid_q    (vld1)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%h expected=%h", tag, got, exp);
    end
  endtask

  function automatic logic [15:0] ref_ext(input logic [11:0] v);
    return v[11] ? {4'hF, v} : {4'h0, v};
  endfunction

  function automatic logic [15:0] ref_tgt(input logic [15:0] p, input logic [11:0] v, input int sh);
    logic [15:0] off;
    off = ref_ext(v) << sh;
    return p + off;
  endfunction

  // One cycle: drive at negedge, check combinational outputs, queue the
  // registered expectation, then compare it after the next rising edge.
  task automatic step(input logic en_i, input logic [11:0] j_i, input logic [15:0] pc_i);
    exp_t x;
    exp_t y;
    @(negedge clk);
    en    = en_i;
    j_imm = j_i;
    pc    = pc_i;
    #1;
    chk("ext", 32'(ext0), 32'(ref_ext(j_i)));
    chk("tgt", 32'(tgt0), 32'(ref_tgt(pc_i, j_i, 0)));
    chk("tgt_sh1", 32'(tgt1), 32'(ref_tgt(pc_i, j_i, 1)));
    if (en_i) begin
      m_e = ref_ext(j_i);
      m_t = ref_tgt(pc_i, j_i, 0);
    end
    m_v = en_i;
    x.e = m_e;
    x.t = m_t;
    x.v = m_v;
    sb.push_back(x);
    @(posedge clk);
    #1;
    if (sb.size() == 0) begin
      chk("sb_empty", 32'(1), 32'(0));
    end else begin
      y = sb.pop_front();
      chk("ext_q", 32'(ext_q0), 32'(y.e));
      chk("tgt_q", 32'(tgt_q0), 32'(y.t));
      chk("valid_q", 32'(vld0), 32'(y.v));
    end
  endtask

  logic [11:0] dir_j [5];
  logic [15:0] dir_e [5];

  initial begin
    dir_j[0] = 12'h05A; dir_e[0] = 16'h005A;
    dir_j[1] = 12'h800; dir_e[1] = 16'hF800;
    dir_j[2] = 12'h000; dir_e[2] = 16'h0000;
    dir_j[3] = 12'h7FF; dir_e[3] = 16'h07FF;
    dir_j[4] = 12'hFFF; dir_e[4] = 16'hFFFF;
    m_e = '0; m_t = '0; m_v = 1'b0;

    rst_n = 1'b0;
    en    = 1'b0;
    j_imm = '0;
    pc    = '0;
    #1;
    chk("rst_ext_q", 32'(ext_q0), 32'(0));
    chk("rst_tgt_q", 32'(tgt_q0), 32'(0));
    chk("rst_valid", 32'(vld0), 32'(0));

    // Combinational extension with fixed constants, one value per ns.
    for (int i = 0; i < 5; i++) begin
      j_imm = dir_j[i];
      #1;
      chk("dir_ext", 32'(ext0), 32'(dir_e[i]));
    end

    @(negedge clk);
    rst_n = 1'b1;

    pc = 16'h0100; j_imm = 12'hFFF; #1;
    chk("tgt_minus1", 32'(tgt0), 32'(16'h00FF));
    pc = 16'hFFFF; j_imm = 12'h001; #1;
    chk("tgt_wrap", 32'(tgt0), 32'(16'h0000));
    pc = 16'h0000; j_imm = 12'h7FF; #1;
    chk("sh1_pos", 32'(tgt1), 32'(16'h0FFE));
    j_imm = 12'h800; #1;
    chk("sh1_neg", 32'(tgt1), 32'(16'hF000));

    // Capture then hold.
    step(1'b1, 12'h800, 16'h0010);
    chk("cap_ext_q", 32'(ext_q0), 32'(16'hF800));
    chk("cap_tgt_q", 32'(tgt_q0), 32'(16'hF810));
    chk("cap_sh1_q", 32'(tgt_q1), 32'(16'hF010));
    step(1'b0, 12'h123, 16'h4444);
    chk("hold_ext_q", 32'(ext_q0), 32'(16'hF800));
    chk("hold_valid", 32'(vld0), 32'(0));
    step(1'b1, 12'h05A, 16'h1000);
    step(1'b1, 12'hABC, 16'h2222);

    // Asynchronous reset between edges.
    @(negedge clk);
    #2;
    rst_n = 1'b0;
    en    = 1'b1;
    j_imm = 12'h9A5;
    #1;
    chk("arst_ext_q", 32'(ext_q0), 32'(0));
    chk("arst_tgt_q", 32'(tgt_q0), 32'(0));
    chk("arst_valid", 32'(vld0), 32'(0));
    chk("arst_ext_comb", 32'(ext0), 32'(16'hF9A5));
    @(posedge clk);
    #1;
    chk("arst_hold_valid", 32'(vld0), 32'(0));
    chk("arst_hold_ext_q", 32'(ext_q0), 32'(0));
    @(negedge clk);
    rst_n = 1'b1;
    m_e = '0; m_t = '0; m_v = 1'b0;
    step(1'b1, 12'h3C3, 16'h8000);

    // Full sweep of the immediate with random pc and enable.
    for (int i = 0; i < 4096; i++) begin
      step(1'($urandom_range(0, 1)), 12'(i), 16'($urandom));
    end

    chk("sb_drained", 32'(sb.size()), 32'(0));
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
